// File: rtl/thermometer_decoder_if.sv
// rtl/thermometer_decoder_if.sv - result handshake bundle for thermometer_decoder
interface thermometer_decoder_if;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] d_out;
   logic       err;

   modport master (
      output out_valid,
      output d_out,
      output err,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  d_out,
      input  err,
      output out_ready
   );
endinterface

// File: rtl/thermometer_decoder.sv
// rtl/thermometer_decoder.sv - synchronised, debounced bar-graph decoder with one-shot valid/ready output
module thermometer_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [6:0]                   d_in,
   thermometer_decoder_if.master        res,
   output logic [7:0]                   err_cnt
);

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [6:0] sync1;
   logic [6:0] s;
   logic [6:0] held;
   logic [3:0] stab_cnt;
   logic       stable;
   logic       load;
   logic       accept;
   logic       clr_stab;
   logic [2:0] dec_val;
   logic       dec_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 7'b0000000;
         s     <= 7'b0000000;
      end else begin
         sync1 <= d_in;
         s     <= sync1;
      end
   end

   // Comparing the incoming stage with s clears the count on the same edge s changes,
   // so the count reflects how long the current s has been held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_cnt <= 4'd0;
      end else if (clr_stab || (sync1 != s)) begin
         stab_cnt <= 4'd0;
      end else if (stab_cnt != STABLE_MAX) begin
         stab_cnt <= stab_cnt + 4'd1;
      end
   end

   assign stable = (stab_cnt == STABLE_MAX);

   always_comb begin
      dec_val = 3'b000;
      dec_err = 1'b0;
      case (s)
         7'b0001000: dec_val = 3'b000;
         7'b0011000: dec_val = 3'b001;
         7'b0111000: dec_val = 3'b010;
         7'b1111000: dec_val = 3'b011;
         7'b0001111: dec_val = 3'b101;
         7'b0001110: dec_val = 3'b110;
         7'b0001100: dec_val = 3'b111;
         default:    dec_err = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      accept     = 1'b0;
      clr_stab   = 1'b0;
      case (state)
         WAIT: begin
            if (stable) begin
               load       = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (res.out_ready) begin
               accept     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            // Any departure from the reported pattern re-arms qualification from zero.
            if (s != held) begin
               clr_stab   = 1'b1;
               state_next = WAIT;
            end
         end
         default: state_next = WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= WAIT;
         res.out_valid <= 1'b0;
      end else begin
         state         <= state_next;
         res.out_valid <= (state_next == EMIT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held      <= 7'b0000000;
         res.d_out <= 3'b000;
         res.err   <= 1'b0;
      end else if (load) begin
         held      <= s;
         res.d_out <= dec_val;
         res.err   <= dec_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (accept && res.err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_thermometer_decoder.sv
// tb/tb_thermometer_decoder.sv - scoreboard bench for thermometer_decoder
module tb_thermometer_decoder;
   localparam int STABLE = 4;

   typedef struct {
      logic [2:0] d;
      logic       e;
   } exp_t;

   typedef struct {
      string name;
      int    act;
      int    req;
   } dchk_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] d_in = 7'b0000000;
   logic [7:0] err_cnt;

   exp_t  exp_q[$];
   dchk_t dir_q[$];
   int    checks = 0;
   int    errors = 0;
   int    model_cnt = 0;
   bit    cnt_pending = 1'b0;

   thermometer_decoder_if res_if ();

   thermometer_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk     (clk),
      .rst     (rst),
      .d_in    (d_in),
      .res     (res_if.master),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   // Reference: legal codes have the centre lit and a single contiguous bar on one side.
   function automatic logic [3:0] ref_decode(input logic [6:0] p);
      int nl;
      int nr;
      nl = $countones(p[6:4]);
      nr = $countones(p[2:0]);
      if (!p[3] || (nl > 0 && nr > 0)) return 4'b1000;
      if (int'(p[6:4]) != ((1 << nl) - 1)) return 4'b1000;
      if (int'(p[2:0]) != ((7 << (3 - nr)) & 7)) return 4'b1000;
      if (nl > 0) return {1'b0, 3'(nl)};
      return {1'b0, 3'(-nr)};
   endfunction

   task automatic push_exp(input logic [6:0] p);
      logic [3:0] r;
      exp_t       x;
      r   = ref_decode(p);
      x.d = r[2:0];
      x.e = r[3];
      exp_q.push_back(x);
   endtask

   task automatic dchk(input string n, input int a, input int r);
      dchk_t c;
      c.name = n;
      c.act  = a;
      c.req  = r;
      dir_q.push_back(c);
   endtask

   task automatic run(input logic [6:0] p, input int hold, input bit emits);
      d_in = p;
      if (emits) push_exp(p);
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input int first_k, output int lat);
      lat = -1;
      for (int k = first_k; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (res_if.out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      dchk_t c;
      exp_t  e;
      while (dir_q.size() > 0) begin
         c = dir_q.pop_front();
         checks++;
         if (c.act != c.req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", c.name, c.act, c.req);
         end
      end
      if (rst) begin
         exp_q.delete();
         model_cnt   = 0;
         cnt_pending = 1'b0;
      end else begin
         if (cnt_pending) begin
            checks++;
            if (int'(err_cnt) != model_cnt) begin
               errors++;
               $display("FAIL err_cnt actual=%0d required=%0d", err_cnt, model_cnt);
            end
            cnt_pending = 1'b0;
         end
         if (res_if.out_valid && res_if.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output actual d_out=%0d err=%0d required no output",
                        res_if.d_out, res_if.err);
            end else begin
               e = exp_q.pop_front();
               if (res_if.d_out !== e.d || res_if.err !== e.e) begin
                  errors++;
                  $display("FAIL result actual d_out=%0d err=%0d required d_out=%0d err=%0d",
                           res_if.d_out, res_if.err, e.d, e.e);
               end
               if (e.e && model_cnt != 255) model_cnt++;
               cnt_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] legal [7];
      logic [6:0] prev;
      logic [6:0] p;
      int         lat;
      int         hold;
      bit         short_run;

      legal[0] = 7'b0001000;
      legal[1] = 7'b0011000;
      legal[2] = 7'b0111000;
      legal[3] = 7'b1111000;
      legal[4] = 7'b0001111;
      legal[5] = 7'b0001110;
      legal[6] = 7'b0001100;

      res_if.out_ready = 1'b1;
      d_in = 7'b0011000;
      repeat (3) @(posedge clk);
      #1;
      dchk("reset_valid", int'(res_if.out_valid), 0);
      dchk("reset_d_out", int'(res_if.d_out), 0);
      dchk("reset_err", int'(res_if.err), 0);
      dchk("reset_err_cnt", int'(err_cnt), 0);
      rst = 1'b0;
      push_exp(7'b0011000);
      wait_valid(0, lat);
      dchk("latency_first", lat, 2 + STABLE);
      @(posedge clk);
      #1;
      dchk("pulse_width", int'(res_if.out_valid), 0);
      repeat (20) begin
         @(posedge clk);
         #1;
      end

      for (int i = 0; i < 7; i++) run(legal[i], 10, 1'b1);
      dchk("err_cnt_sweep", int'(err_cnt), 0);

      run(7'b0101000, 10, 1'b1);
      dchk("err_cnt_noncontig", int'(err_cnt), 1);

      res_if.out_ready = 1'b0;
      d_in = 7'b0001111;
      push_exp(7'b0001111);
      wait_valid(0, lat);
      dchk("stall_valid", int'(res_if.out_valid), 1);
      repeat (3) @(posedge clk);
      #1;
      d_in = 7'b0001100;
      repeat (10) @(posedge clk);
      #1;
      dchk("stall_valid_held", int'(res_if.out_valid), 1);
      dchk("stall_d_out", int'(res_if.d_out), 5);
      push_exp(7'b0001100);
      res_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      wait_valid(1, lat);
      dchk("latency_release", lat, 2 + STABLE);
      repeat (6) @(posedge clk);
      #1;

      run(7'b0001000, 10, 1'b1);
      run(7'b1111000, 2, 1'b0);
      run(7'b0001000, 12, 1'b1);

      prev = 7'b0001000;
      for (int i = 0; i < 60; i++) begin
         short_run = ($urandom_range(0, 3) == 0);
         hold = short_run ? int'($urandom_range(1, 3)) : int'($urandom_range(8, 12));
         do begin
            if ($urandom_range(0, 1) == 0) p = legal[$urandom_range(0, 6)];
            else p = 7'($urandom_range(0, 127));
         end while (p == prev);
         run(p, hold, !short_run);
         prev = p;
      end
      if (prev != 7'b0011000) run(7'b0011000, 10, 1'b1);
      else run(7'b0001000, 10, 1'b1);

      for (int i = 0; i < 256; i++) run((i % 2 == 1) ? 7'b1000001 : 7'b0000000, 8, 1'b1);
      dchk("err_cnt_saturated", int'(err_cnt), 255);

      res_if.out_ready = 1'b0;
      d_in = 7'b0001000;
      push_exp(7'b0001000);
      wait_valid(0, lat);
      dchk("pre_reset_valid", int'(res_if.out_valid), 1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      d_in = 7'b0000000;
      #1;
      dchk("async_reset_valid", int'(res_if.out_valid), 0);
      dchk("async_reset_err_cnt", int'(err_cnt), 0);
      dchk("async_reset_err", int'(res_if.err), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      res_if.out_ready = 1'b1;
      push_exp(7'b0000000);
      repeat (15) @(posedge clk);
      #1;
      dchk("err_cnt_zero_after_reset", int'(err_cnt), 1);
      repeat (5) @(posedge clk);
      #1;
      dchk("queue_empty", exp_q.size(), 0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/thermometer_decoder.md
# thermometer_decoder

Registered decoder for the 7-bit centred bar-graph code produced by the 3-bit thermometer display encoder. It recovers the 3-bit signed value and flags illegal bar patterns. It sits between board switches (or an encoder output looped back) and downstream logic. It synchronises and debounces the raw pattern, decodes each stable pattern once, and delivers it over a valid/ready handshake. It also keeps a saturating count of illegal patterns.

## Interface
- STABLE_CYCLES, 4: consecutive edges the synchronised pattern must stay unchanged before it is decoded; legal range 1..15.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- d_in  in  7  raw bar pattern, asynchronous to clk; bit 3 is the centre segment.
- out_ready  in  1  consumer accepts the result on an edge where out_valid && out_ready.
- out_valid  out  1  result on d_out/err is valid.
- d_out  out  3  decoded value, two's complement.
- err  out  1  the pattern being presented is illegal.
- err_cnt  out  8  number of accepted illegal results; saturates at 255.

## Operation
- Synchroniser: two flops on d_in, both reset to 7'b0000000. The decoder sees only the second-stage value s.
- Stability: a counter clears whenever s differs from its previous value and increments otherwise, saturating at STABLE_CYCLES. A pattern is stable when the counter equals STABLE_CYCLES.
- Decode table (s -> d_out):
  - 0001000 -> 000
  - 0011000 -> 001
  - 0111000 -> 010
  - 1111000 -> 011
  - 0001111 -> 101
  - 0001110 -> 110
  - 0001100 -> 111
  - Any other pattern -> d_out=000, err=1. This includes a clear centre bit, bars on both sides, or non-contiguous bars.
  - Value 100 is never produced; the encoder maps it onto the zero pattern.
- The FSM has three states, with reset state WAIT:
  - WAIT: when the pattern is stable, register the decode result and the pattern (held), then go to EMIT.
  - EMIT: out_valid=1. d_out and err stay frozen even if d_in changes. On out_valid && out_ready, go to DONE. If err=1 at that edge, err_cnt increments unless it is at 255.
  - DONE: out_valid=0. When s != held, clear the stability counter and go to WAIT. A pattern is therefore reported once per stable occurrence, not every cycle.
- Pattern changes while in WAIT restart stability. Changes while in EMIT are ignored until DONE; the new pattern is then re-qualified from zero.
- The first stable pattern after reset is always emitted. This includes 0000000 if d_in is held at zero: err=1 and err_cnt becomes 1 on acceptance.

## Timing
- Reset values: out_valid=0, d_out=000, err=0, err_cnt=0. The FSM is in WAIT, both synchroniser stages are 0000000, and the stability counter is 0.
- Reset asserted mid-handshake clears all of the above immediately. An in-flight result is dropped without incrementing err_cnt.
- Latency: a d_in value first sampled at edge n, and then held, produces out_valid=1 after edge n+2+STABLE_CYCLES. With the default of 4, that is edge n+6.
- out_valid, d_out and err change only on clk edges and are registered outputs; there is no combinational path from d_in or out_ready.
- out_ready held high during EMIT completes the transfer on the first edge of EMIT. The result is visible for exactly one cycle, and out_valid drops the next cycle.
- A glitch on d_in shorter than STABLE_CYCLES cycles, seen at s during WAIT, produces no output.
- err_cnt updates on the same edge as the accepting handshake. It holds at 255 on further illegal acceptances.

## Test plan
- Reset, then d_in=0011000 and out_ready=1 -> out_valid pulses once, 6 edges after the first sampling edge, with d_out=001 and err=0. No further pulse while d_in is held.
- Sweep all 7 legal patterns, each held 10 cycles, with out_ready=1 -> d_out sequence matches the table (000,001,010,011,101,110,111); err stays 0; err_cnt stays 0.
- d_in=0101000 (non-contiguous) with out_ready=1 -> out_valid with d_out=000, err=1; err_cnt becomes 1.
- out_ready=0 with d_in=0001111 -> out_valid stays high with d_out=101. Change d_in to 0001100 while stalled -> d_out stays 101. Raise out_ready -> transfer completes, then d_out=111 is emitted 6 edges after the output is released.
- d_in=0001000 with a 2-cycle pulse to 1111000 after it has been reported -> no new output for the glitch. Return to zero does not re-emit (held=0001000 is unchanged after the glitch clears), except that the glitch itself moves the FSM to WAIT; require exactly one re-emit of 000.
- Drive 256 alternating illegal patterns (0000000 / 1000001), each accepted -> err_cnt saturates at 255. Then assert rst mid-EMIT -> out_valid=0 and err_cnt=0 immediately, without waiting for a clock edge.
